// File: rtl/alu_pkg.sv
// alu_pkg: types, packet constants and CRC helpers shared by the ALU
// receiver, its CRC engine and the bench.
//   operation_t  - legal ALU opcodes
//   rx_state_t   - receiver packet-level state
//   PKT_BITS, PAYLOAD_BITS, TYPE_DATA, TYPE_CTL - packet layout
//   crc4_next    - one serial step of CRC x^4+x+1 (MSB first)
//   crc4         - CRC over a full 68-bit {B, A, 1'b1, op} vector
package alu_pkg;

   localparam int unsigned PKT_BITS     = 11;
   localparam int unsigned PAYLOAD_BITS = PKT_BITS - 3;
   localparam logic        TYPE_DATA    = 1'b0;
   localparam logic        TYPE_CTL     = 1'b1;
   localparam int unsigned CRC_W        = 4;
   localparam int unsigned CRC_MSG_W    = 68;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101
   } operation_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TYPE,
      ST_BYTE,
      ST_STOP
   } rx_state_t;

   // One serial CRC step: feedback = msb ^ incoming bit, taps x^1 and x^0.
   function automatic logic [CRC_W-1:0] crc4_next(input logic [CRC_W-1:0] crc,
                                                  input logic              din);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
   endfunction

   function automatic logic [CRC_W-1:0] crc4(input logic [CRC_MSG_W-1:0] msg);
      logic [CRC_W-1:0] crc;
      crc = '0;
      for (int i = CRC_MSG_W - 1; i >= 0; i--) begin
         crc = crc4_next(crc, msg[i]);
      end
      return crc;
   endfunction

   function automatic logic op_legal(input logic [2:0] opc);
      case (opc)
         OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// alu_crc4_serial: bit-serial CRC x^4+x+1 remainder register, initial 0.
//   clk, rst - clock, synchronous active-high reset
//   din      - message bit, MSB first
//   shift    - fold din into the remainder this cycle
//   clr      - return the remainder to 0 (wins over shift)
//   rem      - current 4-bit remainder
module alu_crc4_serial
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             shift,
   input  logic             clr,
   output logic [CRC_W-1:0] rem
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rem <= '0;
      end else if (shift) begin
         rem <= crc4_next(rem, din);
      end
   end

endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises the single-wire ALU frame (8 DATA packets
// carrying B then A, then one CTL packet with op and CRC), checks framing,
// packet order, CRC and opcode, and strobes the result for one cycle.
//   clk, rst   - clock, synchronous active-high reset
//   sin        - serial line, idles high
//   out_valid  - frame accepted; b, a, op hold the decoded values
//   b, a, op   - last accepted operands/opcode
//   err_data   - framing (stop bit) or packet-order error
//   err_crc    - CRC mismatch
//   err_op     - illegal opcode
// Build option: define ALU_RX_CRC_CHECK_EN to compute and check the CRC;
// without it the CRC field is ignored and err_crc stays 0.
module alu_serial_rx
   import alu_pkg::*;
#(
   parameter int unsigned DATA_PKTS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic        out_valid,
   output logic [31:0] b,
   output logic [31:0] a,
   output logic [2:0]  op,
   output logic        err_data,
   output logic        err_crc,
   output logic        err_op
);

   localparam int unsigned CNT_W   = $clog2(DATA_PKTS + 1);
   localparam int unsigned FRAME_W = 64;
   localparam int unsigned BIT_W   = $clog2(PAYLOAD_BITS);

   rx_state_t                state_q, state_d;
   logic                     type_q;
   logic [BIT_W-1:0]         bit_cnt_q;
   logic [PAYLOAD_BITS-1:0]  byte_q;
   logic [FRAME_W-1:0]       frame_q;
   logic [CNT_W-1:0]         count_q;

   logic store_c;
   logic clear_c;
   logic crc_bad_c;
   logic valid_d, err_data_d, err_crc_d, err_op_d;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and stop-bit dispatch.
   always_comb begin
      state_d    = state_q;
      store_c    = 1'b0;
      clear_c    = 1'b0;
      valid_d    = 1'b0;
      err_data_d = 1'b0;
      err_crc_d  = 1'b0;
      err_op_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (!sin) state_d = ST_TYPE;
         ST_TYPE: state_d = ST_BYTE;
         ST_BYTE: if (bit_cnt_q == BIT_W'(PAYLOAD_BITS - 1)) state_d = ST_STOP;
         ST_STOP: begin
            state_d = ST_IDLE;
            if (!sin) begin
               err_data_d = 1'b1;
               clear_c    = 1'b1;
            end else if (type_q == TYPE_DATA) begin
               if (count_q < CNT_W'(DATA_PKTS)) begin
                  store_c = 1'b1;
               end else begin
                  err_data_d = 1'b1;
                  clear_c    = 1'b1;
               end
            end else if (count_q != CNT_W'(DATA_PKTS)) begin
               err_data_d = 1'b1;
               clear_c    = 1'b1;
            end else begin
               clear_c = 1'b1;
               if (crc_bad_c)                   err_crc_d = 1'b1;
               else if (!op_legal(byte_q[6:4])) err_op_d  = 1'b1;
               else                             valid_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Packet shifter, frame buffer, packet count and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         type_q    <= TYPE_DATA;
         bit_cnt_q <= '0;
         byte_q    <= '0;
         frame_q   <= '0;
         count_q   <= '0;
         out_valid <= 1'b0;
         err_data  <= 1'b0;
         err_crc   <= 1'b0;
         err_op    <= 1'b0;
         b         <= '0;
         a         <= '0;
         op        <= '0;
      end else begin
         if (state_q == ST_TYPE) begin
            type_q    <= sin;
            bit_cnt_q <= '0;
         end
         if (state_q == ST_BYTE) begin
            byte_q    <= {byte_q[PAYLOAD_BITS-2:0], sin};
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
         end
         // Stale bytes need no clearing: acceptance needs 8 fresh stores.
         if (store_c) begin
            frame_q <= {frame_q[FRAME_W-PAYLOAD_BITS-1:0], byte_q};
            count_q <= count_q + CNT_W'(1);
         end
         if (clear_c) count_q <= '0;
         if (valid_d) begin
            b  <= frame_q[63:32];
            a  <= frame_q[31:0];
            op <= byte_q[6:4];
         end
         out_valid <= valid_d;
         err_data  <= err_data_d;
         err_crc   <= err_crc_d;
         err_op    <= err_op_d;
      end
   end

`ifdef ALU_RX_CRC_CHECK_EN
   logic [CRC_W-1:0] crc_rem;
   logic [CRC_W-1:0] crc_fold_c;
   logic             crc_shift_c;

   // Only payload bits that will be stored as operands enter the CRC.
   assign crc_shift_c = (state_q == ST_BYTE) && (type_q == TYPE_DATA) &&
                        (count_q < CNT_W'(DATA_PKTS));

   alu_crc4_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .din   (sin),
      .shift (crc_shift_c),
      .clr   (clear_c),
      .rem   (crc_rem)
   );

   // Fold the trailing {1'b1, op} into the running remainder at CTL time.
   always_comb begin
      crc_fold_c = crc4_next(crc_rem, 1'b1);
      crc_fold_c = crc4_next(crc_fold_c, byte_q[6]);
      crc_fold_c = crc4_next(crc_fold_c, byte_q[5]);
      crc_fold_c = crc4_next(crc_fold_c, byte_q[4]);
   end

   assign crc_bad_c = (crc_fold_c != byte_q[3:0]);
`else
   assign crc_bad_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_rx.sv
// tb_alu_serial_rx: directed and randomized frames for alu_serial_rx,
// checked every cycle against a packet-level reference model.
module tb_alu_serial_rx;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic        sin;
   logic        out_valid;
   logic [31:0] b;
   logic [31:0] a;
   logic [2:0]  op;
   logic        err_data;
   logic        err_crc;
   logic        err_op;

   int total = 0;
   int bad   = 0;

   // Reference model state: bytes received so far in the current frame,
   // expected strobes {out_valid, err_data, err_crc, err_op} for the next
   // sample, and the last accepted operands.
   logic [7:0]  m_bytes[$];
   logic [3:0]  pend;
   logic [31:0] m_a, m_b;
   logic [2:0]  m_op;

   alu_serial_rx #(.DATA_PKTS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .out_valid (out_valid),
      .b         (b),
      .a         (a),
      .op        (op),
      .err_data  (err_data),
      .err_crc   (err_crc),
      .err_op    (err_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CRC as polynomial long division of {msg, 0000} by x^4+x+1.
   function automatic logic [3:0] crc_div(input logic [67:0] msg);
      logic [71:0] r;
      r = {msg, 4'b0000};
      for (int i = 71; i >= 4; i--) begin
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      end
      return r[3:0];
   endfunction

   task automatic model_clear();
      m_bytes.delete();
   endtask

   task automatic model_reset();
      model_clear();
      pend = '0;
      m_a  = '0;
      m_b  = '0;
      m_op = '0;
   endtask

   task automatic model_pkt(input logic t, input logic [7:0] p, input logic stopb);
      logic [31:0] fb, fa;
      logic        crc_ok;
      if (!stopb) begin
         pend = 4'b0100;
         model_clear();
      end else if (t == TYPE_DATA) begin
         if (m_bytes.size() < 8) m_bytes.push_back(p);
         else begin
            pend = 4'b0100;
            model_clear();
         end
      end else if (m_bytes.size() != 8) begin
         pend = 4'b0100;
         model_clear();
      end else begin
         fb = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
         fa = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
         crc_ok = 1'b1;
`ifdef ALU_RX_CRC_CHECK_EN
         crc_ok = (crc_div({fb, fa, 1'b1, p[6:4]}) == p[3:0]);
`endif
         if (!crc_ok) pend = 4'b0010;
         else if (!(p[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) pend = 4'b0001;
         else begin
            pend = 4'b1000;
            m_b  = fb;
            m_a  = fa;
            m_op = p[6:4];
         end
         model_clear();
      end
   endtask

   task automatic check_cycle();
      logic [3:0] got;
      got = {out_valid, err_data, err_crc, err_op};
      total++;
      assert (got === pend) else begin
         bad++;
         $error("FAIL strobes t=%0t observed=%b expected=%b", $time, got, pend);
      end
      total++;
      assert ({b, a, op} === {m_b, m_a, m_op}) else begin
         bad++;
         $error("FAIL operands t=%0t observed b=%h a=%h op=%b expected b=%h a=%h op=%b",
                $time, b, a, op, m_b, m_a, m_op);
      end
      pend = '0;
   endtask

   task automatic send_bit(input logic v);
      @(negedge clk);
      check_cycle();
      sin = v;
   endtask

   task automatic idle(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic send_pkt(input logic t, input logic [7:0] p, input logic stopb);
      send_bit(1'b0);
      send_bit(t);
      for (int i = 7; i >= 0; i--) send_bit(p[i]);
      send_bit(stopb);
      model_pkt(t, p, stopb);
   endtask

   // skip_idx: DATA packet replaced by idle 1s; bad_stop_idx: DATA packet
   // sent with stop bit 0 (use -1 for neither).
   task automatic send_frame(input logic [31:0] fb, input logic [31:0] fa,
                             input logic [2:0] fop, input logic [3:0] crc_delta,
                             input int gap, input int skip_idx, input int bad_stop_idx);
      logic [63:0] data;
      logic [3:0]  crc;
      data = {fb, fa};
      crc  = crc_div({fb, fa, 1'b1, fop}) + crc_delta;
      for (int i = 0; i < 8; i++) begin
         idle(int'($urandom_range(0, gap)));
         if (i == skip_idx) idle(PKT_BITS);
         else send_pkt(TYPE_DATA, data[63-8*i -: 8], (i != bad_stop_idx));
      end
      idle(int'($urandom_range(0, gap)));
      send_pkt(TYPE_CTL, {1'($urandom()), fop, crc}, 1'b1);
   endtask

   task automatic do_reset(input logic chk);
      @(negedge clk);
      if (chk) check_cycle();
      rst = 1'b1;
      sin = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_cycle();
   endtask

   initial begin
      logic [67:0] v;
      rst = 1'b1;
      sin = 1'b1;
      model_reset();

      // Reset state.
      do_reset(1'b0);
      idle(3);

      // Package CRC function agrees with long division.
      for (int i = 0; i < 4; i++) begin
         v = {$urandom(), $urandom(), 4'($urandom())};
         total++;
         assert (crc4(v) === crc_div(v)) else begin
            bad++;
            $error("FAIL pkg_crc4 observed=%h expected=%h", crc4(v), crc_div(v));
         end
      end

      // Clean frame.
      send_frame(32'h2, 32'h1, 3'b100, 4'd0, 0, -1, -1);
      idle(2);
      // CRC off by one.
      send_frame(32'h2, 32'h1, 3'b100, 4'd1, 0, -1, -1);
      idle(2);
      // First B packet replaced by 1s, then a clean frame.
      send_frame(32'h1234_5678, 32'h9abc_def0, 3'b101, 4'd0, 0, 0, -1);
      send_frame(32'h1234_5678, 32'h9abc_def0, 3'b101, 4'd0, 0, -1, -1);
      idle(1);
      // Illegal opcode with valid CRC.
      send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 4'd0, 0, -1, -1);
      idle(1);
      // Stop bit 0 in A[15:8], then recovery.
      send_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b000, 4'd0, 0, -1, 6);
      send_frame(32'hCAFE_0001, 32'h8000_0000, 3'b001, 4'd0, 0, -1, -1);
      idle(1);

      // Reset after 40 frame bits, then a clean all-zero frame.
      send_pkt(TYPE_DATA, 8'h11, 1'b1);
      send_pkt(TYPE_DATA, 8'h22, 1'b1);
      send_pkt(TYPE_DATA, 8'h33, 1'b1);
      send_bit(1'b0);
      send_bit(TYPE_DATA);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom()));
      do_reset(1'b1);
      send_frame(32'h0, 32'h0, 3'b001, 4'd0, 0, -1, -1);
      idle(2);

      // Randomized frames, back-to-back or with short gaps.
      for (int n = 0; n < 30; n++) begin
         send_frame($urandom(), $urandom(), 3'($urandom()),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                    int'($urandom_range(0, 2)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
